// File: rtl/mmio_audio_io_hub.sv
// mmio_audio_io_hub
// Memory-mapped I/O peripheral on the CPU data bus. It provides a synchronised
// switch port, an LED register, NUM_CH glitch-free PWM audio channels and a
// shared sample FIFO that is drained at a fixed sample rate.
//
// Ports
//   i_clk       system clock, all logic on the rising edge
//   i_rst_n     asynchronous active-low reset
//   i_addr      data-memory word address from the CPU
//   i_wdata     store data
//   i_wren      store strobe
//   o_io_sel    combinational, 1 when i_addr is inside the I/O window
//   o_rdata     combinational read data, 0 outside the window
//   i_sw_in     raw asynchronous switches
//   o_led_out   LED register
//   o_pwm_out   registered PWM outputs, one per channel
//   o_fifo_low  1 while the FIFO holds no more than half its depth
//
// Register map (word offsets from BASE_ADDR)
//   0             SW      read-only, synchronised switches
//   1             LED     read/write
//   2..1+NUM_CH   DUTY    read/write shadow duty per channel
//   2+NUM_CH      STATUS  read-only: [8:0] count, [9] full, [10] empty,
//                         [11] overflow, [12] underrun, [23:16] mode
//   3+NUM_CH      CTRL    write: [NUM_CH-1:0] mode, [30] flush, [31] clear flags
//                         read: mode
//   4+NUM_CH      FIFO    write pushes a sample, reads as 0
module mmio_audio_io_hub #(
    parameter int unsigned BASE_ADDR  = 4096,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DUTY_W     = 10,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned SAMPLE_DIV = 1136,
    parameter int unsigned SW_W       = 16,
    parameter int unsigned LED_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    input  logic              i_wren,
    output logic              o_io_sel,
    output logic [31:0]       o_rdata,
    input  logic [SW_W-1:0]   i_sw_in,
    output logic [LED_W-1:0]  o_led_out,
    output logic [NUM_CH-1:0] o_pwm_out,
    output logic              o_fifo_low
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);

    localparam logic [31:0] OFF_SW     = 32'd0;
    localparam logic [31:0] OFF_LED    = 32'd1;
    localparam logic [31:0] OFF_DUTY0  = 32'd2;
    localparam logic [31:0] OFF_STATUS = 32'(2 + NUM_CH);
    localparam logic [31:0] OFF_CTRL   = 32'(3 + NUM_CH);
    localparam logic [31:0] OFF_FIFO   = 32'(4 + NUM_CH);

    logic [SW_W-1:0]   r_sw_meta;
    logic [SW_W-1:0]   r_sw_sync;
    logic [LED_W-1:0]  r_led;
    logic [NUM_CH-1:0] r_mode;
    logic [DUTY_W-1:0] r_duty   [NUM_CH];
    logic [DUTY_W-1:0] r_active [NUM_CH];
    logic [DUTY_W-1:0] r_sample;
    logic [DUTY_W-1:0] r_pwm_cnt;
    logic [NUM_CH-1:0] r_pwm;
    logic [DIV_W-1:0]  r_div;

    logic [DUTY_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              r_unf;

    logic [31:0]       w_offset;
    logic              w_io_sel;
    logic              w_wr;
    logic              w_wr_led;
    logic              w_wr_ctrl;
    logic              w_wr_fifo;
    logic [NUM_CH-1:0] w_wr_duty;
    logic              w_full;
    logic              w_empty;
    logic              w_tick;
    logic              w_stream_any;
    logic              w_flush;
    logic              w_clr;
    logic              w_pop;
    logic              w_push;
    logic              w_ovf_ev;
    logic              w_unf_ev;
    logic              w_wrap;
    logic [31:0]       w_rdata;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_offset  = i_addr - BASE_ADDR;
    assign w_io_sel  = (i_addr >= BASE_ADDR) && (w_offset <= OFF_FIFO);
    assign w_wr      = i_wren && w_io_sel;
    assign w_wr_led  = w_wr && (w_offset == OFF_LED);
    assign w_wr_ctrl = w_wr && (w_offset == OFF_CTRL);
    assign w_wr_fifo = w_wr && (w_offset == OFF_FIFO);

    always_comb begin
        w_wr_duty = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_wr_duty[ch] = w_wr && (w_offset == OFF_DUTY0 + 32'(ch));
        end
    end

    // ------------------------------------------------------------------
    // FIFO / divider control
    // ------------------------------------------------------------------
    assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_tick       = (r_div == DIV_W'(SAMPLE_DIV - 1));
    assign w_stream_any = |r_mode;
    assign w_flush      = w_wr_ctrl && i_wdata[30];
    assign w_clr        = w_wr_ctrl && i_wdata[31];

    // Flush wins over a same-cycle pop; a pop on a full FIFO frees the slot
    // that a same-cycle push then takes, so that push is not an overflow.
    assign w_pop    = w_tick && w_stream_any && !w_empty && !w_flush;
    assign w_unf_ev = w_tick && w_stream_any && w_empty;
    assign w_push   = w_wr_fifo && (!w_full || w_pop);
    assign w_ovf_ev = w_wr_fifo && w_full && !w_pop;

    assign w_wrap = (r_pwm_cnt == '1);

    // ------------------------------------------------------------------
    // Bus-visible registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_led     <= '0;
            r_mode    <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_duty[ch] <= '0;
            end
        end else begin
            r_sw_meta <= i_sw_in;
            r_sw_sync <= r_sw_meta;
            if (w_wr_led) begin
                r_led <= i_wdata[LED_W-1:0];
            end
            if (w_wr_ctrl) begin
                r_mode <= i_wdata[NUM_CH-1:0];
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (w_wr_duty[ch]) begin
                    r_duty[ch] <= i_wdata[DUTY_W-1:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    // Storage is not reset; it is only observable through the pointers.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata[DUTY_W-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_sample <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_div    <= '0;
        end else begin
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end

            // On underrun the sample simply keeps its previous value.
            if (w_pop) begin
                r_sample <= r_mem[r_rd_ptr];
            end

            // Set has priority over a same-cycle clear.
            r_ovf <= (r_ovf && !w_clr) || w_ovf_ev;
            r_unf <= (r_unf && !w_clr) || w_unf_ev;

            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // PWM
    // ------------------------------------------------------------------
    // Active duties only change as the counter wraps to 0, so a period is
    // never cut short or stretched by a mid-period duty update.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pwm_cnt <= '0;
            r_pwm     <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_active[ch] <= '0;
            end
        end else begin
            r_pwm_cnt <= r_pwm_cnt + DUTY_W'(1);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_pwm[ch] <= (r_pwm_cnt < r_active[ch]);
                if (w_wrap) begin
                    r_active[ch] <= r_mode[ch] ? r_sample : r_duty[ch];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        if (w_io_sel) begin
            if (w_offset == OFF_SW) begin
                w_rdata[SW_W-1:0] = r_sw_sync;
            end else if (w_offset == OFF_LED) begin
                w_rdata[LED_W-1:0] = r_led;
            end else if (w_offset == OFF_STATUS) begin
                w_rdata[CNT_W-1:0]   = r_count;
                w_rdata[9]           = w_full;
                w_rdata[10]          = w_empty;
                w_rdata[11]          = r_ovf;
                w_rdata[12]          = r_unf;
                w_rdata[16 +: NUM_CH] = r_mode;
            end else if (w_offset == OFF_CTRL) begin
                w_rdata[NUM_CH-1:0] = r_mode;
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (w_offset == OFF_DUTY0 + 32'(ch)) begin
                    w_rdata[DUTY_W-1:0] = r_duty[ch];
                end
            end
        end
    end

    assign o_io_sel   = w_io_sel;
    assign o_rdata    = w_rdata;
    assign o_led_out  = r_led;
    assign o_pwm_out  = r_pwm;
    assign o_fifo_low = (r_count <= CNT_W'(FIFO_DEPTH / 2));

endmodule

// File: tb/tb_mmio_audio_io_hub.sv
// Testbench for mmio_audio_io_hub. A driver issues directed and random bus
// traffic and, every cycle, pushes the expected outputs (from a queue-based
// reference model) into a scoreboard; a monitor pops and compares on the
// falling edge.
module tb_mmio_audio_io_hub;

    localparam int BASE   = 4096;
    localparam int NCH    = 2;
    localparam int DW     = 10;
    localparam int DEPTH  = 16;
    localparam int SDIV   = 8;
    localparam int PER    = 1 << DW;
    localparam int OFF_ST = 2 + NCH;
    localparam int OFF_CT = 3 + NCH;
    localparam int OFF_FF = 4 + NCH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        wren = 1'b0;
    logic [15:0] sw_in = '0;
    logic        io_sel;
    logic [31:0] rdata;
    logic [15:0] led;
    logic [1:0]  pwm;
    logic        fifo_low;

    mmio_audio_io_hub #(
        .BASE_ADDR(BASE), .NUM_CH(NCH), .DUTY_W(DW), .FIFO_DEPTH(DEPTH),
        .SAMPLE_DIV(SDIV), .SW_W(16), .LED_W(16)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_wdata(wdata),
        .i_wren(wren), .o_io_sel(io_sel), .o_rdata(rdata), .i_sw_in(sw_in),
        .o_led_out(led), .o_pwm_out(pwm), .o_fifo_low(fifo_low)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_t;
    int          m_fifo [$];
    logic [15:0] m_swq [$];
    logic [DW-1:0] m_sample;
    logic [DW-1:0] m_duty [NCH];
    logic [DW-1:0] m_active [NCH];
    logic [1:0]  m_mode;
    logic [1:0]  m_pwm;
    logic [15:0] m_led;
    bit          m_ovf, m_unf;

    task automatic model_reset();
        m_t = 0;
        m_fifo.delete();
        m_swq.delete();
        m_swq.push_back(16'h0);
        m_swq.push_back(16'h0);
        m_sample = '0;
        m_mode = '0;
        m_pwm = '0;
        m_led = '0;
        m_ovf = 0;
        m_unf = 0;
        for (int c = 0; c < NCH; c++) begin
            m_duty[c] = '0;
            m_active[c] = '0;
        end
    endtask

    function automatic bit in_win(logic [31:0] a);
        longint off = longint'(a) - BASE;
        return (off >= 0) && (off <= OFF_FF);
    endfunction

    function automatic logic [31:0] exp_rdata(logic [31:0] a);
        longint off = longint'(a) - BASE;
        logic [31:0] r = '0;
        if (off == 0) r = {16'h0, m_swq[0]};
        else if (off == 1) r = {16'h0, m_led};
        else if (off >= 2 && off < 2 + NCH) r = {22'h0, m_duty[int'(off - 2)]};
        else if (off == OFF_ST) begin
            r[8:0] = 9'(m_fifo.size());
            r[9] = (m_fifo.size() == DEPTH);
            r[10] = (m_fifo.size() == 0);
            r[11] = m_ovf;
            r[12] = m_unf;
            r[17:16] = m_mode;
        end else if (off == OFF_CT) r[1:0] = m_mode;
        return r;
    endfunction

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step();
        int  ph = m_t % PER;
        bit  tick = (m_t % SDIV) == SDIV - 1;
        longint off = longint'(addr) - BASE;
        bit  wr = wren && in_win(addr);
        bit  flush = wr && off == OFF_CT && wdata[30];
        bit  clr = wr && off == OFF_CT && wdata[31];
        bit  stream = (m_mode != 0);
        bit  do_pop = tick && stream && m_fifo.size() > 0 && !flush;
        bit  unf_ev = tick && stream && m_fifo.size() == 0;
        bit  ovf_ev = 0;
        for (int c = 0; c < NCH; c++) begin
            m_pwm[c] = (ph < int'(m_active[c]));
            if (ph == PER - 1) m_active[c] = m_mode[c] ? m_sample : m_duty[c];
        end
        if (do_pop) m_sample = DW'(m_fifo.pop_front());
        if (wr && off == OFF_FF) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(int'(wdata[DW-1:0]));
            else ovf_ev = 1;
        end
        if (flush) m_fifo.delete();
        if (clr) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (ovf_ev) m_ovf = 1;
        if (unf_ev) m_unf = 1;
        if (wr && off == OFF_CT) m_mode = wdata[1:0];
        if (wr && off == 1) m_led = wdata[15:0];
        if (wr && off >= 2 && off < 2 + NCH) m_duty[int'(off - 2)] = wdata[DW-1:0];
        m_swq.push_back(sw_in);
        void'(m_swq.pop_front());
        m_t++;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        string       nm;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    chk_t sb [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic push_chk(string nm, int kind, logic [31:0] e);
        chk_t c;
        c.nm = nm;
        c.kind = kind;
        c.exp = e;
        sb.push_back(c);
    endtask

    task automatic push_checks();
        push_chk("rdata", 0, exp_rdata(addr));
        push_chk("io_sel", 1, {31'h0, in_win(addr)});
        push_chk("led_out", 2, {16'h0, m_led});
        push_chk("pwm_out", 3, {30'h0, m_pwm});
        push_chk("fifo_low", 4, {31'h0, m_fifo.size() <= DEPTH / 2});
    endtask

    initial begin
        chk_t        c;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                c = sb.pop_front();
                case (c.kind)
                    0:       act = rdata;
                    1:       act = {31'h0, io_sel};
                    2:       act = {16'h0, led};
                    3:       act = {30'h0, pwm};
                    default: act = {31'h0, fifo_low};
                endcase
                n_cmp++;
                if (act !== c.exp) begin
                    n_bad++;
                    $display("FAIL %s t=%0t addr=%h got=%h want=%h", c.nm, $time, addr, act, c.exp);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cycle();
        push_checks();
        if (rst_n) model_step();
        else model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(int off, logic [31:0] d);
        addr = 32'(BASE + off);
        wdata = d;
        wren = 1'b1;
        cycle();
        wren = 1'b0;
    endtask

    task automatic rd(int off, int n);
        addr = 32'(BASE + off);
        repeat (n) cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        sw_in = 16'hA5A5;
        @(posedge clk);
        #1;
        rd(0, 3);
        rst_n = 1'b1;

        // switches, LED, window edges
        rd(0, 4);
        wr(1, 32'h0000_00FF);
        rd(1, 2);
        addr = 32'(BASE - 1);
        cycle();
        addr = 32'(BASE + NCH + 5);
        cycle();
        rd(OFF_FF, 1);

        // direct-mode PWM
        rd(OFF_ST, 300);
        wr(2, 256);
        wr(3, 1023);
        rd(2, 2 * PER + 100);
        wr(2, 0);
        rd(3, PER + 50);

        // stream channel 0
        wr(OFF_CT, 32'h1);
        wr(OFF_FF, 100);
        wr(OFF_FF, 200);
        wr(OFF_FF, 300);
        rd(OFF_ST, 40);
        rd(OFF_ST, PER);

        // overflow with stream off, then clear
        wr(OFF_CT, 32'hC000_0000);
        for (int i = 0; i < 17; i++) wr(OFF_FF, $urandom);
        rd(OFF_ST, 3);
        wr(OFF_CT, 32'h8000_0000);
        rd(OFF_ST, 3);
        wr(OFF_CT, 32'h1);
        rd(OFF_ST, 140 + PER);

        // underrun, then push on a tick while full
        wr(OFF_CT, 32'h8000_0001);
        rd(OFF_ST, 20);
        wr(OFF_CT, 32'h0);
        for (int i = 0; i < DEPTH; i++) wr(OFF_FF, $urandom);
        while ((m_t % SDIV) != SDIV - 2) rd(OFF_ST, 1);
        wr(OFF_CT, 32'h8000_0001);
        wr(OFF_FF, 32'h155);
        rd(OFF_ST, 3);

        // reset mid-stream
        wr(OFF_CT, 32'h4000_0000);
        for (int i = 0; i < 5; i++) wr(OFF_FF, $urandom);
        wr(OFF_CT, 32'h1);
        rd(OFF_ST, 1);
        rst_n = 1'b0;
        model_reset();
        rd(OFF_ST, 3);
        rst_n = 1'b1;
        rd(OFF_ST, 3);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int sel = int'($urandom_range(0, 99));
            int off = int'($urandom_range(0, 10)) - 2;
            if (i % 50 == 0) sw_in = 16'($urandom);
            if (sel < 40) rd(off, 1);
            else if (sel < 50) wr(1, $urandom);
            else if (sel < 60) wr(2 + int'($urandom_range(0, NCH - 1)), $urandom);
            else if (sel < 68) wr(OFF_CT, {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 28'h0, 2'($urandom)});
            else if (sel < 93) wr(OFF_FF, $urandom);
            else wr(off, $urandom);
        end
        rd(OFF_ST, 2);

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mmio_audio_io_hub.md
Name: mmio_audio_io_hub

Overview:
Parametrised memory-mapped I/O peripheral for the CPU data bus. It replaces the ad-hoc switch/LED/single-duty-register decode in the top-level wrapper. It holds:
- a synchronised switch input port
- an LED register
- NUM_CH glitch-free PWM audio channels, each in direct-duty mode or stream mode
- a shared sample FIFO that is drained at a fixed sample rate

The wrapper muxes rdata onto q_dmem when io_sel is high.

Parameters:
BASE_ADDR, 4096, first word address of the I/O window
NUM_CH, 2, number of PWM channels (1..8)
DUTY_W, 10, PWM resolution in bits; period is 2^DUTY_W clocks
FIFO_DEPTH, 16, sample FIFO entries (power of two, 2..256)
SAMPLE_DIV, 1136, clocks per sample tick (≥2)
SW_W, 16, switch input width
LED_W, 16, LED register width

Ports:
clock  in  1  system clock (all logic on posedge)
reset  in  1  asynchronous, active-low reset
addr  in  32  data-memory word address from CPU
wdata  in  32  store data
wren  in  1  store strobe
io_sel  out  1  combinational; 1 when BASE_ADDR ≤ addr ≤ BASE_ADDR+NUM_CH+4
rdata  out  32  combinational read data, zero-extended; 0 when io_sel=0
sw_in  in  SW_W  raw switches (asynchronous)
led_out  out  LED_W  LED register
pwm_out  out  NUM_CH  PWM outputs
fifo_low  out  1  1 when FIFO count ≤ FIFO_DEPTH/2

Behaviour:
Reset (asynchronous, while reset=0) clears:
- led_out=0, pwm_out=0
- all duty, shadow and active registers = 0
- mode bits = 0 (direct mode)
- FIFO empty (so fifo_low=1)
- sticky flags, divider and PWM counter = 0
- switch synchronisers = 0

Reset may assert mid-stream; all state returns to the above immediately.

Address map (offset from BASE_ADDR):
- +0 SW: read only; returns the 2-flop-synchronised sw_in. Latency sw_in→readable is 2 clocks.
- +1 LED: read/write. A write loads wdata[LED_W-1:0] on the next edge.
- +2..+1+NUM_CH DUTY[ch]: read/write shadow duty wdata[DUTY_W-1:0].
- +2+NUM_CH STATUS: read only.
  - [8:0] FIFO count
  - [9] full
  - [10] empty
  - [11] sticky overflow
  - [12] sticky underrun
  - [23:16] mode bits
- +3+NUM_CH CTRL: write.
  - [NUM_CH-1:0] mode (1=stream)
  - [30] flush FIFO
  - [31] clear sticky flags
  - Read returns the mode bits.
- +4+NUM_CH FIFO: write pushes wdata[DUTY_W-1:0]. Read returns 0.

Writes to read-only offsets are ignored. Writes outside the window have no effect.

PWM:
- One shared free-running DUTY_W-bit counter, wrapping 2^DUTY_W-1 → 0.
- pwm_out[ch] is registered and equals (counter < active[ch]).
- Duty 0 gives constant low; duty 2^DUTY_W-1 is high for all but 1 clock per period.
- active[ch] loads only on the clock where the counter wraps to 0, so no glitches occur mid-period.
- Source of the loaded value: direct mode → shadow DUTY[ch]; stream mode → current stream sample register.

Sample divider:
- Counts 0..SAMPLE_DIV-1; a tick is asserted on the count value SAMPLE_DIV-1.
- On a tick, if any mode bit is 1:
  - FIFO non-empty → pop the head into the stream sample register.
  - FIFO empty → the stream sample holds its last value and sticky underrun is set.
- On a tick with all mode bits 0, nothing is popped.

FIFO:
- Circular buffer with read/write pointers and a count.
- Push while full: data dropped, overflow set.
- Push and pop on the same clock:
  - When full, the pop frees a slot, so the push is accepted and count is unchanged.
  - When empty, underrun is set and the push is accepted (count goes to 1).
- Flush empties the FIFO and takes priority over a same-cycle pop. The stream sample register is not cleared.
- A clear of the sticky flags and a same-cycle flag-setting event: the set wins.

Test Plan:
1. Reset released; sw_in=16'hA5A5 → read of +0 returns 0 for the first 2 clocks, then 32'h0000A5A5. Write 16'h00FF to +1 → led_out=16'h00FF next clock. io_sel=0 at addr 4095 and 4103 (NUM_CH=2).
2. Direct mode, write DUTY[0]=256 mid-period → pwm_out[0] is unchanged until the counter wrap, then high for exactly 256 of each 1024 clocks. Duty 0 → constant low. Duty 1023 → one low clock per period.
3. CTRL mode=2'b01, push 3 samples (100,200,300), SAMPLE_DIV=8 → pops occur on clocks 8, 16, 24 after the divider starts. Count goes 3→0; fifo_low=1 throughout. Channel 1 stays in direct mode.
4. Push 17 samples into a 16-deep FIFO with stream mode off → count=16, full=1, overflow=1, and the 17th sample is lost. Write CTRL[31] → overflow=0, and the contents stay intact.
5. Stream mode on with an empty FIFO → at the tick, underrun=1 and the stream sample holds its previous value. Push and tick on the same clock while full → count stays 16 and overflow stays 0.
6. Assert reset mid-stream with count=5 and pwm high → all outputs 0 and the FIFO empty immediately, without waiting for a clock edge.
